shift_sequencer: RTL and testbench

Multi-cycle shift engine controller. Accepts one operand, an operation code and a shift amount over a valid/ready handshake. Applies one single-position shift per clock until the amount is exhausted, then presents the result over a valid/ready handshake. Sits between an operator-issue stage and result writeback, and shares one shift-step datapath across all six shift/rotate operations.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_step.sv | 24 ++
 rtl/shift_sequencer.sv | 127 ++++++++++++
 tb/tb_shift_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer: operation codes, FSM states and op legality.
package shift_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_LSL = 3'b000;
   localparam logic [OP_W-1:0] OP_LSR = 3'b001;
   localparam logic [OP_W-1:0] OP_ASL = 3'b010;
   localparam logic [OP_W-1:0] OP_ASR = 3'b011;
   localparam logic [OP_W-1:0] OP_ROL = 3'b100;
   localparam logic [OP_W-1:0] OP_ROR = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op != 3'b110) && (op != 3'b111);
   endfunction

endpackage

// File: rtl/shift_step.sv
// Single-position shift/rotate step shared by all six operations; illegal ops pass data through.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] d,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] q
);

   always_comb begin
      q = d;
      case (op)
         OP_LSL, OP_ASL: q = {d[WIDTH-2:0], 1'b0};
         OP_LSR:         q = {1'b0, d[WIDTH-1:1]};
         OP_ASR:         q = {d[WIDTH-1], d[WIDTH-1:1]};
         OP_ROL:         q = {d[WIDTH-2:0], d[WIDTH-1]};
         OP_ROR:         q = {d[0], d[WIDTH-1:1]};
         default:        q = d;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: accepts one request, applies one shift step per clock, then
// holds the registered result until the consumer takes it or the operation is aborted.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic             busy
);

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_data;
   logic [OP_W-1:0]  r_op;
   logic [AMT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_err;
   logic [WIDTH-1:0] w_step;
   logic             w_accept;
   logic             w_enter_done;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_shift_step (
      .d  (r_data),
      .op (r_op),
      .q  (w_step)
   );

   // abort outranks in_valid in IDLE
   assign w_accept     = (r_state == ST_IDLE) && in_valid && !abort;
   assign w_enter_done = (r_state != ST_DONE) && (w_state_next == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = ((in_amt == '0) || !is_legal_op(in_op)) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (r_cnt == AMT_W'(1)) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (abort || out_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         ST_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_op   <= OP_LSL;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_data <= in_data;
         r_op   <= in_op;
         r_cnt  <= in_amt;
      end else if ((r_state == ST_SHIFT) && !abort) begin
         r_data <= w_step;
         r_cnt  <= r_cnt - AMT_W'(1);
      end
   end

   // Result registers load only on entry to DONE so they hold across the next request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data <= '0;
         r_out_err  <= 1'b0;
      end else if (w_enter_done) begin
         if (r_state == ST_IDLE) begin
            r_out_data <= in_data;
            r_out_err  <= !is_legal_op(in_op);
         end else begin
            r_out_data <= w_step;
            r_out_err  <= !is_legal_op(r_op);
         end
      end
   end

   assign out_data = r_out_data;
   assign out_err  = r_out_err;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer at WIDTH=4, AMT_W=3.
module tb_shift_sequencer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned AMT_W = 3;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_data;
   logic [AMT_W-1:0] in_amt;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_err;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   shift_sequencer #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents a request for one edge, then scrambles the inputs to prove single sampling.
   task automatic start_op(input string tag, input logic [2:0] op, input logic [3:0] d,
                           input logic [2:0] amt);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_amt   = amt;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op    = ~op;
      in_data  = ~d;
      in_amt   = amt + 3'd1;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int k = 0;
      while (!out_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'(exp_lat));
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_released"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] d,
                         input logic [2:0] amt, input logic [3:0] exp_d, input logic exp_e,
                         input int exp_lat);
      start_op(tag, op, d, amt);
      wait_done(tag, exp_lat);
      check({tag, "_data"}, 32'(out_data), 32'(exp_d));
      check({tag, "_err"}, 32'(out_err), 32'(exp_e));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      release_result(tag);
   endtask

   initial begin
      logic [3:0] held;
      logic       seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 3'b000;
      in_data   = '0;
      in_amt    = '0;
      abort     = 1'b0;
      out_ready = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("lsl_0100_1", 3'b000, 4'b0100, 3'd1, 4'b1000, 1'b0, 1);
      run_op("lsl_1000_1", 3'b000, 4'b1000, 3'd1, 4'b0000, 1'b0, 1);
      run_op("lsr_0001_1", 3'b001, 4'b0001, 3'd1, 4'b0000, 1'b0, 1);
      run_op("lsr_1000_3", 3'b001, 4'b1000, 3'd3, 4'b0001, 1'b0, 3);
      run_op("asr_1000_1", 3'b011, 4'b1000, 3'd1, 4'b1100, 1'b0, 1);
      run_op("asr_1000_7", 3'b011, 4'b1000, 3'd7, 4'b1111, 1'b0, 7);
      run_op("asr_0100_2", 3'b011, 4'b0100, 3'd2, 4'b0001, 1'b0, 2);
      run_op("asl_0001_1", 3'b010, 4'b0001, 3'd1, 4'b0010, 1'b0, 1);
      run_op("rol_1001_1", 3'b100, 4'b1001, 3'd1, 4'b0011, 1'b0, 1);
      run_op("ror_0001_5", 3'b101, 4'b0001, 3'd5, 4'b1000, 1'b0, 5);
      run_op("rol_0110_4", 3'b100, 4'b0110, 3'd4, 4'b0110, 1'b0, 4);
      run_op("lsl_0001_7", 3'b000, 4'b0001, 3'd7, 4'b0000, 1'b0, 7);
      run_op("lsr_amt0", 3'b001, 4'b1011, 3'd0, 4'b1011, 1'b0, 0);
      run_op("ill_111", 3'b111, 4'b1010, 3'd3, 4'b1010, 1'b1, 0);
      run_op("after_ill", 3'b000, 4'b0011, 3'd2, 4'b1100, 1'b0, 2);
      run_op("ill_110", 3'b110, 4'b0110, 3'd5, 4'b0110, 1'b1, 0);

      // Backpressure: result and handshake stay frozen, a new request is ignored.
      start_op("bp", 3'b101, 4'b0011, 3'd1);
      wait_done("bp", 1);
      held = out_data;
      check("bp_data", 32'(held), 32'b1001);
      in_valid = 1'b1;
      in_op    = 3'b000;
      in_data  = 4'b0111;
      in_amt   = 3'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_stable", 32'(out_data), 32'(held));
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bp_idle", 32'(busy), 32'd0);
      check("bp_in_ready_after", 32'(in_ready), 32'd1);
      run_op("bp_next", 3'b000, 4'b0101, 3'd1, 4'b1010, 1'b0, 1);

      // Abort during SHIFT discards the operation.
      start_op("abort_shift", 3'b001, 4'b1111, 3'd6);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_shift_busy", 32'(busy), 32'd0);
      check("abort_shift_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      check("abort_shift_no_result", 32'(seen), 32'd0);

      // Abort in IDLE blocks acceptance.
      in_valid = 1'b1;
      in_op    = 3'b000;
      in_data  = 4'b0001;
      in_amt   = 3'd1;
      abort    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      abort    = 1'b0;
      check("abort_idle_busy", 32'(busy), 32'd0);

      // Abort in DONE drops out_valid without out_ready.
      start_op("abort_done", 3'b000, 4'b1011, 3'd0);
      check("abort_done_valid", 32'(out_valid), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_done_dropped", 32'(out_valid), 32'd0);
      check("abort_done_idle", 32'(in_ready), 32'd1);

      // Asynchronous reset in the middle of SHIFT.
      start_op("rst_mid", 3'b000, 4'b0001, 3'd6);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_in_ready", 32'(in_ready), 32'd1);
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_out_data", 32'(out_data), 32'd0);
      check("rst_mid_out_err", 32'(out_err), 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("post_rst", 3'b011, 4'b0110, 3'd1, 4'b0011, 1'b0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
